// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display sharing logic: hex glyphs
// (active-high, dp clear), blank pattern and arbiter state encoding.
package seg_pkg;

  localparam logic [7:0] SEG_HEX_0 = 8'hFC;
  localparam logic [7:0] SEG_HEX_1 = 8'h60;
  localparam logic [7:0] SEG_HEX_2 = 8'hDA;
  localparam logic [7:0] SEG_HEX_3 = 8'hF2;
  localparam logic [7:0] SEG_HEX_4 = 8'h66;
  localparam logic [7:0] SEG_HEX_5 = 8'hB6;
  localparam logic [7:0] SEG_HEX_6 = 8'hBE;
  localparam logic [7:0] SEG_HEX_7 = 8'hE0;
  localparam logic [7:0] SEG_HEX_8 = 8'hFE;
  localparam logic [7:0] SEG_HEX_9 = 8'hF6;
  localparam logic [7:0] SEG_HEX_A = 8'hEE;
  localparam logic [7:0] SEG_HEX_B = 8'h3E;
  localparam logic [7:0] SEG_HEX_C = 8'h9C;
  localparam logic [7:0] SEG_HEX_D = 8'h7A;
  localparam logic [7:0] SEG_HEX_E = 8'h9E;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg_hex2seg.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
// Bit7=a ... bit1=g, bit0=dp.
module seg_hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] pat;

  always_comb begin
    case (nibble)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      4'hF: pat = SEG_HEX_F;
    endcase
  end

  assign seg = ~(pat | {7'b0, dp});

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin sharing of the 8-digit seven-segment display among N_REQ
// requesters; each accepted message is held for HOLD_CYC cycles.
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_CYC = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [8*N_REQ-1:0]   req_dp,
  output logic [7:0]           o_seg0,
  output logic [7:0]           o_seg1,
  output logic [7:0]           o_seg2,
  output logic [7:0]           o_seg3,
  output logic [7:0]           o_seg4,
  output logic [7:0]           o_seg5,
  output logic [7:0]           o_seg6,
  output logic [7:0]           o_seg7,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam int unsigned    PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0]    N_REQ_W = (PW + 1)'(N_REQ);
  localparam logic [31:0]    CNT_END = 32'(HOLD_CYC - 1);

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant_r;
  logic [31:0]      hold_cnt;
  logic [7:0]       seg_r   [8];
  logic [7:0]       seg_nxt [8];

  logic [N_REQ-1:0] rot;
  logic             found;
  logic [PW:0]      sum;
  logic [PW:0]      sum_nxt;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    winner_nxt;
  logic [31:0]      sel_data;
  logic [7:0]       sel_dp;
  logic             accept;

  // Rotate valids so bit 0 is the rr pointer; first set bit is the offset of the winner.
  always_comb begin
    rot   = N_REQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (PW + 1)'(i);
      end
    end
    if (sum >= N_REQ_W) sum = sum - N_REQ_W;
    winner = sum[PW-1:0];

    sum_nxt = {1'b0, winner} + (PW + 1)'(1);
    if (sum_nxt >= N_REQ_W) sum_nxt = '0;
    winner_nxt = sum_nxt[PW-1:0];
  end

  assign req_ready = (!rst && state == IDLE && found) ? (N_REQ'(1) << winner) : '0;
  assign accept    = |req_ready;

  assign sel_data = req_data[32'(winner) * 32 +: 32];
  assign sel_dp   = req_dp[32'(winner) * 8 +: 8];

  for (genvar k = 0; k < 8; k++) begin : g_dig
    seg_hex2seg u_hex2seg (
      .nibble (sel_data[4*k +: 4]),
      .dp     (sel_dp[k]),
      .seg    (seg_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_r  <= '0;
      hold_cnt <= '0;
      for (int unsigned k = 0; k < 8; k++) seg_r[k] <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_r  <= winner;
            rr_ptr   <= winner_nxt;
            hold_cnt <= '0;
            state    <= HOLD;
            for (int unsigned k = 0; k < 8; k++) seg_r[k] <= seg_nxt[k];
          end
        end
        HOLD: begin
          if (hold_cnt == CNT_END) begin
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == HOLD);
  assign grant_id = 3'(grant_r);

  assign o_seg0 = seg_r[0];
  assign o_seg1 = seg_r[1];
  assign o_seg2 = seg_r[2];
  assign o_seg3 = seg_r[3];
  assign o_seg4 = seg_r[4];
  assign o_seg5 = seg_r[5];
  assign o_seg6 = seg_r[6];
  assign o_seg7 = seg_r[7];

endmodule
